// File: rtl/conway_pkg.sv
// conway_pkg: shared FSM encodings, default B5/S45 rule masks and indexing helpers
// for the 3D Game-of-Life engine.
package conway_pkg;
   localparam logic [3:0] Q_SETUP   = 4'b0001;
   localparam logic [3:0] Q_SIMUL   = 4'b0010;
   localparam logic [3:0] Q_COMPUTE = 4'b0100;
   localparam logic [3:0] Q_PAUSE   = 4'b1000;
   localparam logic [26:0] DEF_BIRTH   = 27'h0000020;
   localparam logic [26:0] DEF_SURVIVE = 27'h0000030;
   function automatic int cell_index(input int x, input int y, input int z, input int dim_x, input int dim_y);
      return x + dim_x * (y + dim_y * z);
   endfunction
   // Width of a counter over d values, never zero so size-1 axes stay legal.
   function automatic int coord_w(input int d);
      return d > 1 ? $clog2(d) : 1;
   endfunction
endpackage

// File: rtl/conway_neighbor_count.sv
// conway_neighbor_count: combinational 26-neighbour live count for one cell
// and its next state under the selected rule masks and edge mode.
module conway_neighbor_count import conway_pkg::*; #(
   parameter int DIM_X = 8,
   parameter int DIM_Y = 8,
   parameter int DIM_Z = 8,
   parameter int WRAP = 1,
   parameter logic [26:0] BIRTH_MASK = DEF_BIRTH,
   parameter logic [26:0] SURVIVE_MASK = DEF_SURVIVE,
   localparam int N = DIM_X * DIM_Y * DIM_Z,
   localparam int XW = coord_w(DIM_X),
   localparam int YW = coord_w(DIM_Y),
   localparam int ZW = coord_w(DIM_Z),
   localparam int IW = coord_w(N)
) (
   input  logic [N-1:0]  cells,
   input  logic [XW-1:0] x,
   input  logic [YW-1:0] y,
   input  logic [ZW-1:0] z,
   output logic [4:0]    count,
   output logic          nxt
);
   int nx, ny, nz;
   logic ok;
   // Axes shorter than 3 are bounded even when wrapping, so no neighbour is counted twice.
   always_comb begin
      count = '0;
      nx = 0;
      ny = 0;
      nz = 0;
      ok = 1'b0;
      for (int k = -1; k <= 1; k++)
         for (int j = -1; j <= 1; j++)
            for (int i = -1; i <= 1; i++) begin
               nx = int'(x) + i;
               ny = int'(y) + j;
               nz = int'(z) + k;
               ok = (i != 0) || (j != 0) || (k != 0);
               if (WRAP != 0 && DIM_X >= 3) nx = (nx + DIM_X) % DIM_X;
               else ok = ok && nx >= 0 && nx < DIM_X;
               if (WRAP != 0 && DIM_Y >= 3) ny = (ny + DIM_Y) % DIM_Y;
               else ok = ok && ny >= 0 && ny < DIM_Y;
               if (WRAP != 0 && DIM_Z >= 3) nz = (nz + DIM_Z) % DIM_Z;
               else ok = ok && nz >= 0 && nz < DIM_Z;
               if (ok) count = count + 5'(cells[IW'(cell_index(nx, ny, nz, DIM_X, DIM_Y))]);
            end
      nxt = cells[IW'(cell_index(int'(x), int'(y), int'(z), DIM_X, DIM_Y))] ? SURVIVE_MASK[count] : BIRTH_MASK[count];
   end
endmodule

// File: rtl/conway_life_engine.sv
// conway_life_engine: setup/simulate/pause FSM with a serial one-cell-per-clock
// sweep into a shadow buffer that is committed atomically each generation.
module conway_life_engine import conway_pkg::*; #(
   parameter int DIM_X = 8,
   parameter int DIM_Y = 8,
   parameter int DIM_Z = 8,
   parameter int WRAP = 1,
   parameter logic [26:0] BIRTH_MASK = DEF_BIRTH,
   parameter logic [26:0] SURVIVE_MASK = DEF_SURVIVE,
   parameter int GEN_W = 16,
   localparam int N = DIM_X * DIM_Y * DIM_Z,
   localparam int AW = $clog2(N),
   localparam int PW = $clog2(N + 1)
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic             End,
   input  logic             Running,
   input  logic             Step,
   input  logic             Tick,
   input  logic             EditWe,
   input  logic [AW-1:0]    EditAddr,
   input  logic             EditData,
   output logic [N-1:0]     Cells,
   output logic [GEN_W-1:0] Generation,
   output logic [PW-1:0]    Population,
   output logic             Busy,
   output logic             GenDone,
   output logic             Overrun
);
   localparam int XW = coord_w(DIM_X);
   localparam int YW = coord_w(DIM_Y);
   localparam int ZW = coord_w(DIM_Z);
   logic [3:0] state;
   logic ret_pause, commit, nxt, edit_ok;
   logic [AW-1:0] idx;
   logic [XW-1:0] sx;
   logic [YW-1:0] sy;
   logic [ZW-1:0] sz;
   logic [N-1:0] shadow;
   logic [PW-1:0] acc;
   logic [4:0] count_unused;
   conway_neighbor_count #(
      .DIM_X(DIM_X), .DIM_Y(DIM_Y), .DIM_Z(DIM_Z), .WRAP(WRAP),
      .BIRTH_MASK(BIRTH_MASK), .SURVIVE_MASK(SURVIVE_MASK)
   ) u_nc (.cells(Cells), .x(sx), .y(sy), .z(sz), .count(count_unused), .nxt(nxt));
   assign edit_ok = EditWe && ({1'b0, EditAddr} < (AW + 1)'(N));
   assign Busy = state == Q_COMPUTE && !commit;
   assign GenDone = state == Q_COMPUTE && commit;
   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) begin
         state <= Q_SETUP;
         ret_pause <= 1'b0;
         commit <= 1'b0;
         idx <= '0;
         sx <= '0;
         sy <= '0;
         sz <= '0;
         shadow <= '0;
         acc <= '0;
         Cells <= '0;
         Generation <= '0;
         Population <= '0;
         Overrun <= 1'b0;
      end else begin
         if (End) state <= Q_SETUP;
         else if (state == Q_SETUP) begin
            if (edit_ok && Cells[EditAddr] != EditData) begin
               Cells[EditAddr] <= EditData;
               Population <= EditData ? Population + PW'(1) : Population - PW'(1);
            end
            if (Start) begin
               state <= Q_SIMUL;
               Generation <= '0;
               Overrun <= 1'b0;
            end
         end else if (state == Q_SIMUL) begin
            if (!Running) state <= Q_PAUSE;
            else if (Tick) begin
               state <= Q_COMPUTE;
               ret_pause <= 1'b0;
            end
         end else if (state == Q_PAUSE) begin
            if (Running) state <= Q_SIMUL;
            else if (Step) begin
               state <= Q_COMPUTE;
               ret_pause <= 1'b1;
            end
         end else begin
            if (Tick) Overrun <= 1'b1;
            if (commit) begin
               Cells <= shadow;
               Population <= acc;
               Generation <= Generation + GEN_W'(1);
               state <= (ret_pause || !Running) ? Q_PAUSE : Q_SIMUL;
            end else begin
               shadow[idx] <= nxt;
               acc <= acc + PW'(nxt);
               idx <= idx + AW'(1);
               commit <= idx == AW'(N - 1);
               if (sx == XW'(DIM_X - 1)) begin
                  sx <= '0;
                  if (sy == YW'(DIM_Y - 1)) begin
                     sy <= '0;
                     sz <= sz + ZW'(1);
                  end else sy <= sy + YW'(1);
               end else sx <= sx + XW'(1);
            end
         end
         // Commit or abort rewinds the sweep so the next one starts at cell 0.
         if (End || commit) begin
            commit <= 1'b0;
            idx <= '0;
            sx <= '0;
            sy <= '0;
            sz <= '0;
            acc <= '0;
         end
      end
endmodule

// File: tb/tb_conway_life_engine.sv
// tb_conway_life_engine: directed checks of editing, sweep timing, pause/step,
// overrun, abort, reset, wrap/bounded edges and a 2D blinker.
module tb_conway_life_engine;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0, stop = 1'b0, run = 1'b0, stp = 1'b0, tick = 1'b0, we = 1'b0, data = 1'b0;
   logic [8:0] addr = '0;
   logic [511:0] d_cells, n_cells;
   logic [15:0] d_gen, n_gen;
   logic [9:0] d_pop, n_pop;
   logic d_busy, d_done, d_ovr, n_busy, n_done, n_ovr;
   logic b_start = 1'b0, b_stop = 1'b0, b_run = 1'b0, b_stp = 1'b0, b_tick = 1'b0, b_we = 1'b0, b_data = 1'b0;
   logic [4:0] b_addr = '0;
   logic [24:0] b_cells;
   logic [15:0] b_gen;
   logic [4:0] b_pop;
   logic b_busy, b_done, b_ovr;
   logic [511:0] pat, corners;
   int pat_idx[5];
   int n_cmp = 0, n_bad = 0, nb;

   always #5 clk = ~clk;

   conway_life_engine u_d (
      .Clk(clk), .Reset_n(rst_n), .Start(start), .End(stop), .Running(run), .Step(stp), .Tick(tick),
      .EditWe(we), .EditAddr(addr), .EditData(data), .Cells(d_cells), .Generation(d_gen),
      .Population(d_pop), .Busy(d_busy), .GenDone(d_done), .Overrun(d_ovr));
   conway_life_engine #(.WRAP(0)) u_n (
      .Clk(clk), .Reset_n(rst_n), .Start(start), .End(stop), .Running(run), .Step(stp), .Tick(tick),
      .EditWe(we), .EditAddr(addr), .EditData(data), .Cells(n_cells), .Generation(n_gen),
      .Population(n_pop), .Busy(n_busy), .GenDone(n_done), .Overrun(n_ovr));
   conway_life_engine #(.DIM_X(5), .DIM_Y(5), .DIM_Z(1), .WRAP(0), .BIRTH_MASK(27'h8), .SURVIVE_MASK(27'hC)) u_b (
      .Clk(clk), .Reset_n(rst_n), .Start(b_start), .End(b_stop), .Running(b_run), .Step(b_stp), .Tick(b_tick),
      .EditWe(b_we), .EditAddr(b_addr), .EditData(b_data), .Cells(b_cells), .Generation(b_gen),
      .Population(b_pop), .Busy(b_busy), .GenDone(b_done), .Overrun(b_ovr));

   task automatic clk_n(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic finish_sweep(input bit blk);
      int c = 0;
      while ((blk ? b_done : d_done) !== 1'b1 && c < 1000) begin
         clk_n(1);
         c++;
      end
      chk(blk ? "b_done_seen" : "d_done_seen", blk ? b_done : d_done, 1);
      clk_n(1);
   endtask

   initial begin
      pat_idx = '{0, 63, 455, 504, 511};
      pat = '0;
      foreach (pat_idx[i]) pat[pat_idx[i]] = 1'b1;
      corners = pat;
      corners[7] = 1'b1;
      corners[56] = 1'b1;
      corners[448] = 1'b1;
      #3;
      chk("rst_cells", d_cells, 0);
      chk("rst_gen", d_gen, 0);
      chk("rst_pop", d_pop, 0);
      chk("rst_busy", d_busy, 0);
      chk("rst_done", d_done, 0);
      chk("rst_ovr", d_ovr, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clk_n(1);
      // single live cell dies after exactly one full sweep
      we = 1'b1; addr = 9'd0; data = 1'b1;
      clk_n(1);
      we = 1'b0;
      chk("edit_cells", d_cells, 1);
      chk("edit_pop", d_pop, 1);
      we = 1'b1; addr = 9'd0; data = 1'b1;
      clk_n(1);
      we = 1'b0;
      chk("edit_same_pop", d_pop, 1);
      start = 1'b1; run = 1'b1;
      clk_n(1);
      start = 1'b0;
      tick = 1'b1;
      clk_n(1);
      tick = 1'b0;
      nb = 0;
      while (d_busy === 1'b1 && nb < 600) begin
         nb++;
         clk_n(1);
      end
      chk("busy_cycles", nb, 512);
      chk("commit_done", d_done, 1);
      chk("commit_cells_old", d_cells, 1);
      chk("commit_gen_old", d_gen, 0);
      clk_n(1);
      chk("gen1_cells", d_cells, 0);
      chk("gen1_pop", d_pop, 0);
      chk("gen1_gen", d_gen, 1);
      chk("gen1_done_low", d_done, 0);
      chk("gen1_n_gen", n_gen, 1);
      // pause then single step
      run = 1'b0;
      clk_n(1);
      stp = 1'b1;
      clk_n(1);
      stp = 1'b0;
      chk("step_busy", d_busy, 1);
      finish_sweep(0);
      chk("step_gen", d_gen, 2);
      chk("step_idle", d_busy, 0);
      tick = 1'b1;
      clk_n(1);
      tick = 1'b0;
      clk_n(2);
      chk("pause_tick_busy", d_busy, 0);
      chk("pause_tick_gen", d_gen, 2);
      // tick arriving mid-sweep is dropped but flagged
      run = 1'b1;
      clk_n(1);
      tick = 1'b1;
      clk_n(1);
      tick = 1'b0;
      clk_n(99);
      tick = 1'b1;
      clk_n(1);
      tick = 1'b0;
      chk("overrun_set", d_ovr, 1);
      finish_sweep(0);
      chk("overrun_gen", d_gen, 3);
      clk_n(3);
      chk("overrun_no_extra", d_busy, 0);
      chk("overrun_gen_hold", d_gen, 3);
      chk("overrun_sticky", d_ovr, 1);
      // load wrap pattern, abort a sweep, then run it to completion
      stop = 1'b1;
      clk_n(1);
      stop = 1'b0;
      foreach (pat_idx[i]) begin
         we = 1'b1; addr = 9'(pat_idx[i]); data = 1'b1;
         clk_n(1);
      end
      we = 1'b0;
      chk("pat_cells", d_cells, pat);
      chk("pat_pop", d_pop, 5);
      start = 1'b1;
      clk_n(1);
      start = 1'b0;
      chk("start_ovr_clr", d_ovr, 0);
      chk("start_gen_clr", d_gen, 0);
      tick = 1'b1;
      clk_n(1);
      tick = 1'b0;
      clk_n(199);
      stop = 1'b1;
      clk_n(1);
      stop = 1'b0;
      chk("abort_busy", d_busy, 0);
      chk("abort_cells", d_cells, pat);
      chk("abort_gen", d_gen, 0);
      chk("abort_pop", d_pop, 5);
      start = 1'b1;
      clk_n(1);
      start = 1'b0;
      tick = 1'b1;
      clk_n(1);
      tick = 1'b0;
      finish_sweep(0);
      chk("wrap_cells", d_cells, corners);
      chk("wrap_pop", d_pop, 8);
      chk("wrap_gen", d_gen, 1);
      chk("wrap_survivor", d_cells[511], 1);
      chk("bound_cells", n_cells, 0);
      chk("bound_pop", n_pop, 0);
      chk("bound_gen", n_gen, 1);
      // asynchronous reset in the middle of a sweep
      tick = 1'b1;
      clk_n(1);
      tick = 1'b0;
      clk_n(50);
      chk("pre_rst_busy", d_busy, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_cells", d_cells, 0);
      chk("mid_rst_gen", d_gen, 0);
      chk("mid_rst_pop", d_pop, 0);
      chk("mid_rst_busy", d_busy, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clk_n(1);
      we = 1'b1; addr = 9'd5; data = 1'b1;
      clk_n(1);
      we = 1'b0;
      chk("post_rst_setup_pop", d_pop, 1);
      we = 1'b1; addr = 9'd5; data = 1'b0;
      clk_n(1);
      we = 1'b0;
      chk("clear_pop", d_pop, 0);
      // 2D Conway blinker on the 5x5x1 bounded instance
      for (int i = 11; i <= 13; i++) begin
         b_we = 1'b1; b_addr = 5'(i); b_data = 1'b1;
         clk_n(1);
      end
      b_we = 1'b1; b_addr = 5'd30; b_data = 1'b1;
      clk_n(1);
      b_we = 1'b0;
      chk("blk_load_cells", b_cells, 25'h0003800);
      chk("blk_load_pop", b_pop, 3);
      b_start = 1'b1; b_run = 1'b1;
      clk_n(1);
      b_start = 1'b0;
      b_tick = 1'b1;
      clk_n(1);
      b_tick = 1'b0;
      finish_sweep(1);
      chk("blk_g1_cells", b_cells, 25'h0021080);
      chk("blk_g1_pop", b_pop, 3);
      chk("blk_g1_gen", b_gen, 1);
      b_tick = 1'b1;
      clk_n(1);
      b_tick = 1'b0;
      finish_sweep(1);
      chk("blk_g2_cells", b_cells, 25'h0003800);
      chk("blk_g2_pop", b_pop, 3);
      chk("blk_g2_gen", b_gen, 2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/conway_life_engine.md
Name: conway_life_engine

Overview:
- Parametrised 3D Game-of-Life engine for an X×Y×Z cell volume. Default 8×8×8 = 512 cells, driving the LED cube.
- Contains the setup/simulate/pause control FSM.
- In SETUP, cells are loaded through an edit port.
- In SIMUL, or on a single step from PAUSE, the engine computes one generation. It sweeps serially, one cell per clock, into a shadow buffer, then commits the buffer atomically.
- Rule set and edge mode (toroidal or bounded) are selectable.

Parameters:
- DIM_X, 8: cells along x.
- DIM_Y, 8: cells along y.
- DIM_Z, 8: cells along z.
- WRAP, 1: 1 = toroidal edges, 0 = out-of-range neighbours count as dead.
- BIRTH_MASK, 27'h0000020: bit n set = a dead cell with n live neighbours is born (default B5).
- SURVIVE_MASK, 27'h0000030: bit n set = a live cell with n live neighbours survives (default S45).
- GEN_W, 16: width of the generation counter.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- Start  in  1  level; SETUP -> SIMUL.
- End  in  1  level; any state -> SETUP, with priority over all other inputs.
- Running  in  1  level; 1 = run, 0 = pause.
- Step  in  1  one-cycle pulse; in PAUSE, compute exactly one generation.
- Tick  in  1  one-cycle pulse; generation-rate strobe used in SIMUL.
- EditWe  in  1  cell write strobe; honoured in SETUP only.
- EditAddr  in  clog2(N)  cell index, idx = x + DIM_X*y + DIM_X*DIM_Y*z.
- EditData  in  1  value written to the addressed cell.
- Cells  out  N  committed cell state, N = DIM_X*DIM_Y*DIM_Z.
- Generation  out  GEN_W  number of committed generations.
- Population  out  clog2(N+1)  live-cell count of Cells.
- Busy  out  1  high while a sweep is in progress.
- GenDone  out  1  one-cycle pulse on the commit cycle.
- Overrun  out  1  sticky; a Tick arrived while Busy.

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - state = SETUP.
  - Cells, shadow buffer, Generation, Population, Busy, GenDone and Overrun are all 0.
  - Sweep index = 0.
- States are one-hot: SETUP, SIMUL, COMPUTE, PAUSE.
- SETUP:
  - EditWe writes Cells[EditAddr] <= EditData on the next edge.
  - Population updates on the same edge: +1, -1 or unchanged.
  - EditAddr >= N is ignored.
  - Start=1 -> SIMUL, and Generation and Overrun clear to 0.
  - EditWe and Start in the same cycle: the write takes effect, then the state transition.
- SIMUL:
  - End -> SETUP.
  - else Running=0 -> PAUSE.
  - else Tick -> COMPUTE.
- PAUSE:
  - End -> SETUP.
  - else Running=1 -> SIMUL.
  - else Step -> COMPUTE, with return target PAUSE.
- COMPUTE:
  - Busy=1 throughout.
  - Each cycle, evaluate cell idx from the committed Cells: count its 26 neighbours (0..26, 5-bit).
  - next = alive ? SURVIVE_MASK[count] : BIRTH_MASK[count].
  - Write next to shadow[idx] and accumulate a running population; idx increments.
  - A full sweep takes N cycles (idx 0..N-1).
  - On the cycle after idx = N-1 (commit cycle):
    - Cells <= shadow, Population <= accumulated count.
    - Generation increments, wrapping at 2^GEN_W.
    - GenDone pulses and Busy drops.
    - Return target: PAUSE if entered via Step or if Running=0 at commit; otherwise SIMUL.
  - Tick-to-Cells latency: N+1 cycles after the Tick edge.
  - End during COMPUTE aborts immediately to SETUP. The shadow buffer is discarded; Cells, Generation and Population keep their committed values.
  - Tick during COMPUTE is dropped and sets Overrun. Overrun clears only on SETUP->SIMUL or on reset.
  - Running and Step are ignored mid-sweep, except that Running is sampled at commit.
- Edge rules:
  - WRAP=1: neighbour coordinates are taken modulo the dimension. Wrap applies only to dimensions with size >= 3; smaller dimensions are treated as bounded, so no neighbour is counted twice.
  - WRAP=0: out-of-range neighbours count as 0.
- Cells never change except by an edit in SETUP or at a commit.
- Reset asserted mid-sweep returns everything to reset values immediately.

Decomposition:
- Shared package conway_pkg:
  - state localparams (one-hot Q_SETUP, Q_SIMUL, Q_COMPUTE, Q_PAUSE);
  - function cell_index(x, y, z);
  - default rule masks.
- Sub-module conway_neighbor_count, combinational:
  - inputs: Cells vector and coordinate (x, y, z);
  - outputs: 5-bit live-neighbour count and next-state bit;
  - parameters: DIM_*, WRAP and rule masks.
- The top level holds the FSM, sweep counter, shadow buffer, population accumulator and edit logic.

Test Plan:
- Reset_n low mid-run with cells loaded -> next cycle Cells=0, Generation=0, Population=0, Busy=0, state SETUP.
- Default 8×8×8: edit a single cell idx 0 to 1, Start, Running=1, Tick -> Busy for 512 cycles; on cycle 513 Cells=0, Population 1->0, Generation=1, GenDone for one cycle.
- DIM 5×5×1, WRAP=0, BIRTH=bit3, SURVIVE=bits 2,3 (2D Conway): load a horizontal blinker at idx 11,12,13 and issue Ticks:
  - after generation 1, Cells = idx 7,12,17;
  - after generation 2, Cells = idx 11,12,13;
  - Population stays 3 throughout.
- PAUSE with Running=0: Step pulse -> exactly one sweep; state returns to PAUSE and Generation increments by 1. A second Tick while paused has no effect.
- Tick issued at sweep cycle 100 -> Overrun=1 and Generation increments only once. End at sweep cycle 200 -> SETUP with Cells equal to the pre-sweep value and Generation unchanged.
- WRAP=1, 8×8×8: a live cell at (7,7,7) plus 4 live neighbours at x=0 / y=0 / z=0 across the wrap -> survives (count 4). The same pattern with WRAP=0 -> the cell dies.
